// File: rtl/wvb_occupancy_ctrl.sv
// wvb_occupancy_ctrl
//   Per-channel waveform-buffer occupancy tracker. Derives words-in-use from the
//   writer's next address and the last address retired by the reader, raises a
//   delayed, abortable overflow toward the write controller, and keeps slow-control
//   status: high-water flag, peak occupancy and a saturating overflow-entry count.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   wvb_wr_addr    address the writer will write next
//   wvb_rddone     one-cycle strobe, reader retired one event
//   rd_stop_addr   last address of the retired event (valid with wvb_rddone)
//   hdr_full       header FIFO full (passed straight to overflow)
//   hwm_thresh     high-water threshold in words, 0 disables
//   ovf_clr        request to leave the overflow state
//   peak_clr       reload peak tracker with current occupancy
//   overflow       hdr_full OR buffer in overflow state
//   wvb_wused      registered words in use, zero-extended
//   wvb_wused_peak maximum wvb_wused since reset or peak_clr
//   hwm_flag       registered (wvb_wused >= hwm_thresh) && hwm_thresh != 0
//   ovf_count      number of overflow-state entries, saturating at 0xFFFF
module wvb_occupancy_ctrl #(
   parameter int unsigned P_ADR_WIDTH = 12,
   parameter int unsigned P_OVF_DELAY = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [P_ADR_WIDTH-1:0] wvb_wr_addr,
   input  logic                   wvb_rddone,
   input  logic [P_ADR_WIDTH-1:0] rd_stop_addr,
   input  logic                   hdr_full,
   input  logic [15:0]            hwm_thresh,
   input  logic                   ovf_clr,
   input  logic                   peak_clr,
   output logic                   overflow,
   output logic [15:0]            wvb_wused,
   output logic [15:0]            wvb_wused_peak,
   output logic                   hwm_flag,
   output logic [15:0]            ovf_count
);

   localparam logic [P_ADR_WIDTH-1:0] AdrOne  = P_ADR_WIDTH'(1);
   localparam logic [7:0]             CntLast = 8'(P_OVF_DELAY - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StArm  = 2'd1,
      StOvf  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [P_ADR_WIDTH-1:0] last_rd_q;
   logic [15:0]            wused_q;
   logic [15:0]            peak_q;
   logic                   hwm_q;
   logic [15:0]            ovf_count_q;

   logic                   at_limit;
   logic [P_ADR_WIDTH-1:0] used;
   logic [15:0]            used_ext;
   logic                   ovf_enter;

   // The slot at last_rd_addr is never written, so writer == last_rd means full.
   assign at_limit = (wvb_wr_addr == last_rd_q);
   assign used     = wvb_wr_addr - last_rd_q - AdrOne;
   assign used_ext = {{(16 - P_ADR_WIDTH){1'b0}}, used};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ovf_enter = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (at_limit) begin
               if (P_OVF_DELAY > 1) begin
                  state_d = StArm;
                  cnt_d   = 8'd1;
               end else begin
                  state_d   = StOvf;
                  cnt_d     = 8'd0;
                  ovf_enter = 1'b1;
               end
            end
         end
         StArm: begin
            if (!at_limit) begin
               // Reader freed space before the delay expired.
               state_d = StIdle;
               cnt_d   = 8'd0;
            end else if (cnt_q == CntLast) begin
               state_d   = StOvf;
               cnt_d     = 8'd0;
               ovf_enter = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StOvf: begin
            // A clear while still full is dropped, not held pending.
            if (ovf_clr && !at_limit) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         last_rd_q   <= '1;
         wused_q     <= 16'd0;
         peak_q      <= 16'd0;
         hwm_q       <= 1'b0;
         ovf_count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (wvb_rddone) begin
            last_rd_q <= rd_stop_addr;
         end
         wused_q <= used_ext;
         hwm_q   <= (hwm_thresh != 16'd0) && (used_ext >= hwm_thresh);
         if (peak_clr) begin
            peak_q <= used_ext;
         end else if (used_ext > peak_q) begin
            peak_q <= used_ext;
         end
         if (ovf_enter && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_q <= ovf_count_q + 16'd1;
         end
      end
   end

   assign overflow       = hdr_full | (state_q == StOvf);
   assign wvb_wused      = wused_q;
   assign wvb_wused_peak = peak_q;
   assign hwm_flag       = hwm_q;
   assign ovf_count      = ovf_count_q;

endmodule

// File: tb/tb_wvb_occupancy_ctrl.sv
// Scoreboard bench for wvb_occupancy_ctrl (P_ADR_WIDTH=4, P_OVF_DELAY=3).
// Stimulus pushes hand-computed expectations tagged with the cycle they apply to;
// a monitor on the falling edge pops and compares every entry due that cycle.
module tb_wvb_occupancy_ctrl;

   localparam int unsigned AW = 4;

   localparam int SIG_WUSED = 0;
   localparam int SIG_PEAK  = 1;
   localparam int SIG_HWM   = 2;
   localparam int SIG_OVF   = 3;
   localparam int SIG_CNT   = 4;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] wvb_wr_addr;
   logic          wvb_rddone;
   logic [AW-1:0] rd_stop_addr;
   logic          hdr_full;
   logic [15:0]   hwm_thresh;
   logic          ovf_clr;
   logic          peak_clr;
   logic          overflow;
   logic [15:0]   wvb_wused;
   logic [15:0]   wvb_wused_peak;
   logic          hwm_flag;
   logic [15:0]   ovf_count;

   typedef struct {
      int          cyc;
      int          sig;
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   wvb_occupancy_ctrl #(
      .P_ADR_WIDTH (AW),
      .P_OVF_DELAY (3)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wvb_wr_addr    (wvb_wr_addr),
      .wvb_rddone     (wvb_rddone),
      .rd_stop_addr   (rd_stop_addr),
      .hdr_full       (hdr_full),
      .hwm_thresh     (hwm_thresh),
      .ovf_clr        (ovf_clr),
      .peak_clr       (peak_clr),
      .overflow       (overflow),
      .wvb_wused      (wvb_wused),
      .wvb_wused_peak (wvb_wused_peak),
      .hwm_flag       (hwm_flag),
      .ovf_count      (ovf_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] get_sig(input int sig);
      case (sig)
         SIG_WUSED: get_sig = wvb_wused;
         SIG_PEAK:  get_sig = wvb_wused_peak;
         SIG_HWM:   get_sig = {15'd0, hwm_flag};
         SIG_OVF:   get_sig = {15'd0, overflow};
         default:   get_sig = ovf_count;
      endcase
   endfunction

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            logic [15:0] act;
            act = get_sig(sb[i].sig);
            checks = checks + 1;
            if (act !== sb[i].val) begin
               failures = failures + 1;
               $display("FAIL %s cycle=%0d actual=%0h expected=%0h",
                        sb[i].name, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s stale expectation for cycle=%0d", sb[i].name, sb[i].cyc);
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int dly, input int sig, input logic [15:0] v,
                            input string name);
      exp_t e;
      e.cyc  = cyc + dly;
      e.sig  = sig;
      e.val  = v;
      e.name = name;
      sb.push_back(e);
   endtask

   initial begin
      rst_n        = 1'b0;
      wvb_wr_addr  = 4'd0;
      wvb_rddone   = 1'b0;
      rd_stop_addr = 4'd0;
      hdr_full     = 1'b0;
      hwm_thresh   = 16'd0;
      ovf_clr      = 1'b0;
      peak_clr     = 1'b0;
      step();
      step();

      // Reset state (cycle 2), then wr_addr=5 with last_rd=15 -> used 5.
      rst_n = 1'b1;
      expect_at(0, SIG_WUSED, 16'd0, "rst_wused");
      expect_at(0, SIG_PEAK, 16'd0, "rst_peak");
      expect_at(0, SIG_HWM, 16'd0, "rst_hwm");
      expect_at(0, SIG_OVF, 16'd0, "rst_ovf");
      expect_at(0, SIG_CNT, 16'd0, "rst_cnt");
      wvb_wr_addr = 4'd5;
      expect_at(1, SIG_WUSED, 16'd5, "wused_5");
      expect_at(1, SIG_PEAK, 16'd5, "peak_5");
      step();

      // Fill to limit (cycle 3): overflow rises 3 cycles later.
      wvb_wr_addr = 4'd15;
      expect_at(1, SIG_WUSED, 16'd15, "fill_wused");
      expect_at(1, SIG_PEAK, 16'd15, "fill_peak");
      expect_at(1, SIG_HWM, 16'd0, "hwm_disabled");
      expect_at(0, SIG_OVF, 16'd0, "fill_ovf_c0");
      expect_at(1, SIG_OVF, 16'd0, "fill_ovf_c1");
      expect_at(2, SIG_OVF, 16'd0, "fill_ovf_c2");
      expect_at(2, SIG_CNT, 16'd0, "fill_cnt_before");
      expect_at(3, SIG_OVF, 16'd1, "fill_ovf_c3");
      expect_at(3, SIG_CNT, 16'd1, "fill_cnt_after");
      repeat (3) step();

      // Cycle 6: clear while still full is ignored.
      ovf_clr = 1'b1;
      expect_at(1, SIG_OVF, 16'd1, "clr_ignored");
      step();
      // Cycle 7: retire to 7, no clear -> earlier clear not remembered.
      ovf_clr      = 1'b0;
      wvb_rddone   = 1'b1;
      rd_stop_addr = 4'd7;
      expect_at(1, SIG_OVF, 16'd1, "clr_not_held");
      expect_at(2, SIG_WUSED, 16'd7, "clr_wused");
      step();
      // Cycle 8: clear with space available -> leaves OVF next cycle.
      wvb_rddone = 1'b0;
      ovf_clr    = 1'b1;
      expect_at(1, SIG_OVF, 16'd0, "clr_exit");
      step();
      // Cycle 9: refill to last_rd=7.
      ovf_clr     = 1'b0;
      wvb_wr_addr = 4'd7;
      expect_at(2, SIG_OVF, 16'd0, "refill_ovf_c2");
      expect_at(2, SIG_CNT, 16'd1, "refill_cnt_before");
      expect_at(3, SIG_OVF, 16'd1, "refill_ovf_c3");
      expect_at(3, SIG_CNT, 16'd2, "refill_cnt_after");
      repeat (3) step();
      // Cycle 12: retire to 3, then clear at 13.
      wvb_rddone   = 1'b1;
      rd_stop_addr = 4'd3;
      step();
      wvb_rddone = 1'b0;
      ovf_clr    = 1'b1;
      expect_at(1, SIG_OVF, 16'd0, "exit2");
      expect_at(1, SIG_WUSED, 16'd3, "exit2_wused");
      step();

      // Abort (cycle 14): set last_rd=15, then wr=15 for 2 cycles, retire to 3.
      ovf_clr      = 1'b0;
      wvb_rddone   = 1'b1;
      rd_stop_addr = 4'd15;
      step();
      wvb_rddone  = 1'b0;
      wvb_wr_addr = 4'd15;
      for (int d = 0; d < 5; d++) expect_at(d, SIG_OVF, 16'd0, "abort_no_ovf");
      step();
      wvb_rddone   = 1'b1;
      rd_stop_addr = 4'd3;
      expect_at(2, SIG_WUSED, 16'd11, "abort_wused");
      expect_at(2, SIG_CNT, 16'd2, "abort_cnt");
      step();
      wvb_rddone = 1'b0;
      step();

      // HWM / peak / wrap (cycle 18): last_rd -> 13, thresh 10.
      wvb_rddone   = 1'b1;
      rd_stop_addr = 4'd13;
      hwm_thresh   = 16'd10;
      step();
      wvb_rddone = 1'b0;
      for (int k = 0; k < 12; k++) begin
         wvb_wr_addr = 4'((14 + k) % 16);
         peak_clr    = (k == 0);
         expect_at(1, SIG_WUSED, 16'(k), "wrap_wused");
         expect_at(1, SIG_HWM, (k >= 10) ? 16'd1 : 16'd0, "wrap_hwm");
         expect_at(1, SIG_PEAK, 16'(k), "wrap_peak");
         step();
      end
      // Cycle 31: peak_clr with used=4 loads 4, not 0.
      wvb_wr_addr = 4'd2;
      peak_clr    = 1'b1;
      expect_at(1, SIG_PEAK, 16'd4, "peak_clr_4");
      expect_at(1, SIG_WUSED, 16'd4, "peak_clr_wused");
      expect_at(1, SIG_HWM, 16'd0, "hwm_drop");
      step();
      peak_clr = 1'b0;
      expect_at(1, SIG_PEAK, 16'd4, "peak_hold");
      step();

      // hdr_full (cycle 33): combinational, no state change.
      hdr_full = 1'b1;
      expect_at(0, SIG_OVF, 16'd1, "hdr_full_ovf");
      expect_at(1, SIG_CNT, 16'd2, "hdr_full_cnt");
      step();
      hdr_full = 1'b0;
      expect_at(0, SIG_OVF, 16'd0, "hdr_full_release");

      // Reset mid-operation while arming (wr=13 == last_rd).
      wvb_wr_addr = 4'd13;
      step();
      rst_n = 1'b0;
      step();
      rst_n       = 1'b1;
      wvb_wr_addr = 4'd0;
      expect_at(0, SIG_WUSED, 16'd0, "mid_rst_wused");
      expect_at(0, SIG_PEAK, 16'd0, "mid_rst_peak");
      expect_at(0, SIG_CNT, 16'd0, "mid_rst_cnt");
      expect_at(0, SIG_HWM, 16'd0, "mid_rst_hwm");
      for (int d = 0; d < 4; d++) expect_at(d, SIG_OVF, 16'd0, "mid_rst_ovf");
      repeat (5) step();

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wvb_occupancy_ctrl.md
# wvb_occupancy_ctrl

Parametrised successor to the per-channel waveform-buffer overflow controller. It tracks buffer occupancy from the writer address and the reader's event-done strobe, and raises a delayed, abortable overflow toward the write controller. It also provides a high-water-mark flag, a peak-occupancy tracker, and a saturating overflow-event counter for slow control. One instance sits between each channel's waveform buffer write controller and its readout arbiter.

## Interface
- P_ADR_WIDTH, 12: buffer address width; depth = 2^P_ADR_WIDTH, legal range 4..15.
- P_OVF_DELAY, 7: cycles the at-limit condition must persist before overflow asserts; legal range 1..255.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wvb_wr_addr  in  P_ADR_WIDTH  address the writer will write next.
- wvb_rddone  in  1  one-cycle strobe; reader finished one event.
- rd_stop_addr  in  P_ADR_WIDTH  last address of the event being retired; valid with wvb_rddone.
- hdr_full  in  1  header FIFO full.
- hwm_thresh  in  16  high-water threshold in words; 0 disables.
- ovf_clr  in  1  request to leave the overflow state.
- peak_clr  in  1  clears wvb_wused_peak.
- overflow  out  1  hdr_full OR buffer overflow state.
- wvb_wused  out  16  words in use, zero-extended.
- wvb_wused_peak  out  16  maximum wvb_wused since the last reset or peak_clr.
- hwm_flag  out  1  wvb_wused >= hwm_thresh, with hwm_thresh nonzero.
- ovf_count  out  16  number of overflow-state entries, saturating.

## Operation
- **last_rd_addr register** (P_ADR_WIDTH bits): reset value all ones; loads rd_stop_addr on any cycle with wvb_rddone=1.
- **at_limit**: wvb_wr_addr == last_rd_addr, evaluated against the current registered last_rd_addr. One slot is always kept as a guard.
- **Occupancy**: used = (wvb_wr_addr - last_rd_addr - 1) mod 2^P_ADR_WIDTH, giving a range of 0..2^P_ADR_WIDTH-1. The value equals 2^P_ADR_WIDTH-1 exactly when at_limit is true. It is registered into wvb_wused[P_ADR_WIDTH-1:0] with the upper bits forced to 0.
- **hwm_flag**: registered; hwm_flag <= (hwm_thresh != 0) && (used >= hwm_thresh). Both operands are 16-bit.
- **wvb_wused_peak**: updated when used > peak. peak_clr loads the current used value rather than 0, and takes priority over the update.
- **Overflow FSM**, with states IDLE, ARM and OVF plus an 8-bit counter cnt:
  - IDLE: if at_limit, then go to ARM with cnt=1 when P_OVF_DELAY>1, or go directly to OVF when P_OVF_DELAY=1.
  - ARM: if !at_limit, go to IDLE with cnt=0 (abort; the reader freed space). Else if cnt == P_OVF_DELAY-1, go to OVF. Else cnt++.
  - OVF: stays in OVF until a cycle with ovf_clr=1 and !at_limit, then goes to IDLE. ovf_clr while at_limit holds is ignored and is not remembered.
- **ovf_count**: increments on every transition into OVF; saturates at 0xFFFF.
- **overflow output**: combinational OR of hdr_full and (state==OVF). There is no register on hdr_full.
- **Reset mid-operation**: every register returns to its reset value regardless of state.

## Timing
- **Reset values** (first cycle after the reset edge):
  - wvb_wused=0, wvb_wused_peak=0, hwm_flag=0, ovf_count=0.
  - State IDLE, last_rd_addr all ones.
  - overflow equals hdr_full.
- **Register latency**: wvb_wused, hwm_flag and wvb_wused_peak each lag wvb_wr_addr / last_rd_addr by 1 cycle. last_rd_addr lags wvb_rddone by 1 cycle, so occupancy reflects a retired event 2 cycles after the strobe.
- **Overflow latency**: if at_limit is true at cycles c..c+P_OVF_DELAY-1, overflow is high from cycle c+P_OVF_DELAY. If at_limit drops at any cycle before that, overflow never rises.
- **Simultaneous wvb_rddone and at_limit**: the FSM uses the old last_rd_addr. Abort or exit takes effect on the following cycle.
- **Wrap-around**: all address arithmetic is modulo 2^P_ADR_WIDTH; there is no special case at address 0.
- **Simultaneous peak_clr and a new maximum**: the peak takes the current used value (identical result either way).

## Test plan
P_ADR_WIDTH=4, P_OVF_DELAY=3.
- **Reset**: rst_n=0 for 2 cycles with wr_addr=0 -> wvb_wused=0, overflow=0, ovf_count=0. Then wr_addr=5 -> wvb_wused=5 one cycle later.
- **Fill to limit**: wr_addr=15 held with no rddone -> wvb_wused=15; overflow rises exactly 3 cycles after wr_addr=15 is applied; ovf_count=1.
- **Abort**: wr_addr=15 for 2 cycles, then rddone with rd_stop_addr=3 -> overflow never rises; wvb_wused=11 two cycles after the strobe; ovf_count unchanged.
- **Clear**: in OVF, ovf_clr while wr_addr=15 -> stays in OVF. Then rddone with stop=7, followed by ovf_clr -> overflow drops the next cycle. A refill re-enters OVF and ovf_count=2.
- **HWM, peak and wrap**: hwm_thresh=10; last_rd=13, wr_addr stepping 14,15,0..9 -> wvb_wused 0..11; hwm_flag rises when wvb_wused=10; peak=11. peak_clr with used=4 -> peak=4.
- **hdr_full**: hdr_full=1 in IDLE -> overflow=1 in the same cycle with no state change and ovf_count unchanged.
